// File: rtl/partition_arb_pkg.sv
// Shared FSM state type and sizing helpers for the partition request arbiter.
package partition_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } arb_state_e;

  function automatic int grant_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int credit_width(input int credit_max);
    return $clog2(credit_max + 1);
  endfunction

endpackage

// File: rtl/partition_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr, with wrap.
module rr_pick
  import partition_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = grant_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [GW-1:0] idx,
  output logic          any
);

  int            cand;
  logic [GW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = GW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/partition_req_arbiter.sv
// Round-robin arbiter sequencing one partition-engine transaction at a time.
// Optional watchdog enabled by defining PARTITION_ARB_TIMEOUT_EN.
module partition_req_arbiter
  import partition_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DSIZE       = 32,
  parameter int CREDIT_INIT = 4,
  parameter int CREDIT_MAX  = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic                    part_valid,
  input  logic                    part_ready,
  output logic [DSIZE-1:0]        part_data,
  input  logic                    pp_valid,
  output logic                    pp_ready,
  input  logic                    credit_ret,
  input  logic                    wl_valid,
  output logic                    wl_ready,
  output logic [NREQ-1:0]         done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int GW = grant_width(NREQ);
  localparam int CW = credit_width(CREDIT_MAX);
  localparam logic [CW-1:0] CINIT = CW'(CREDIT_INIT);
  localparam logic [CW-1:0] CMAX  = CW'(CREDIT_MAX);
  localparam logic [GW-1:0] LAST  = GW'(NREQ - 1);

  arb_state_e       state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic [DSIZE-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic [CW-1:0]    credit_q, credit_d;

  logic [NREQ-1:0]  pick_grant;
  logic [GW-1:0]    pick_idx;
  logic             pick_any;
  logic [DSIZE-1:0] sel_data;
  logic             pp_hs;

  rr_pick #(.N(NREQ), .GW(GW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) sel_data = req_data[i*DSIZE +: DSIZE];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    pdata_d   = pdata_q;
    pvalid_d  = pvalid_q;
    req_ready = '0;
    pp_ready  = 1'b0;
    wl_ready  = 1'b0;
    done      = '0;
    case (state_q)
      IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          pdata_d  = sel_data;
          gid_d    = pick_idx;
          pvalid_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (part_ready) begin
          pvalid_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        pp_ready = (credit_q != '0);
        wl_ready = 1'b1;
        if (wl_valid) state_d = FINISH;
      end
      FINISH: begin
        done[gid_q] = 1'b1;
        ptr_d       = (gid_q == LAST) ? '0 : gid_q + GW'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pulse granted and a credit returned in the same cycle cancel out.
  always_comb begin
    pp_hs    = pp_valid && pp_ready;
    credit_d = credit_q;
    if (pp_hs && !credit_ret)
      credit_d = credit_q - CW'(1);
    else if (!pp_hs && credit_ret && credit_q != CMAX)
      credit_d = credit_q + CW'(1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gid_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      credit_q <= CINIT;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      credit_q <= credit_d;
    end
  end

  assign part_valid = pvalid_q;
  assign part_data  = pdata_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q != IDLE);

`ifdef PARTITION_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT);

  logic [WW-1:0] wd_q, wd_d;
  logic          terr_q, terr_d;

  // Watchdog measures idle time within RUN; it saturates and the flag is sticky.
  always_comb begin
    wd_d = wd_q;
    if (state_d == RUN && state_q != RUN)
      wd_d = '0;
    else if (state_q == RUN) begin
      if (pp_hs || wl_valid)
        wd_d = '0;
      else if (wd_q != WLIM)
        wd_d = wd_q + WW'(1);
    end
    terr_d = terr_q || (wd_d == WLIM);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_partition_req_arbiter.sv
// Directed self-checking bench for partition_req_arbiter (optionally with PARTITION_ARB_TIMEOUT_EN).
module tb_partition_req_arbiter;

  localparam int NREQ        = 4;
  localparam int DSIZE       = 32;
  localparam int CREDIT_INIT = 4;
  localparam int CREDIT_MAX  = 8;
  localparam int TIMEOUT     = 16;

  logic                  clock = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  part_valid;
  logic                  part_ready;
  logic [DSIZE-1:0]      part_data;
  logic                  pp_valid;
  logic                  pp_ready;
  logic                  credit_ret;
  logic                  wl_valid;
  logic                  wl_ready;
  logic [NREQ-1:0]       done;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  timeout_err;

  int vec_count  = 0;
  int miss_count = 0;

  partition_req_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .CREDIT_INIT(CREDIT_INIT),
    .CREDIT_MAX(CREDIT_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .part_valid(part_valid), .part_ready(part_ready), .part_data(part_data),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .credit_ret(credit_ret),
    .wl_valid(wl_valid), .wl_ready(wl_ready), .done(done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] global time limit expired");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    part_ready = 1'b0;
    pp_valid   = 1'b0;
    credit_ret = 1'b0;
    wl_valid   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Grants the given request pattern and walks through ISSUE; returns in RUN.
  task automatic start_txn(input logic [NREQ-1:0] rv);
    req_valid = rv;
    tick();
    req_valid  = '0;
    part_ready = 1'b1;
    tick();
    part_ready = 1'b0;
  endtask

  task automatic finish_txn();
    wl_valid = 1'b1;
    tick();
    wl_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input int cycles, output int hs);
    hs = 0;
    pp_valid = 1'b1;
    repeat (cycles) begin
      if (pp_ready) hs++;
      tick();
    end
    pp_valid = 1'b0;
  endtask

  task automatic pulse_ret(input int n);
    repeat (n) begin
      credit_ret = 1'b1;
      tick();
    end
    credit_ret = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req_data = '0;
    rst_n = 1'b0;
    @(negedge clock);
    tick();
    vec_count++; if (busy !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vec_count++; if (part_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_part_valid: got %b expected 0", part_valid); end
    vec_count++; if (part_data !== 32'h0) begin miss_count++; $display("[TB] FAIL reset_part_data: got %h expected 0", part_data); end
    vec_count++; if (grant_id !== 2'd0) begin miss_count++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
    vec_count++; if (done !== 4'b0000) begin miss_count++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
    vec_count++; if (req_ready !== 4'b0000) begin miss_count++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    vec_count++; if (pp_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_pp_ready: got %b expected 0", pp_ready); end
    vec_count++; if (wl_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_wl_ready: got %b expected 0", wl_ready); end
    vec_count++; if (timeout_err !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_data[31:0] = 32'h1234_0100;
    req_valid = 4'b0001;
    #1;
    vec_count++; if (req_ready !== 4'b0001) begin miss_count++; $display("[TB] FAIL single_req_ready: got %b expected 0001", req_ready); end
    tick();
    vec_count++; if (part_valid !== 1'b1) begin miss_count++; $display("[TB] FAIL single_part_valid: got %b expected 1", part_valid); end
    vec_count++; if (part_data !== 32'h1234_0100) begin miss_count++; $display("[TB] FAIL single_part_data: got %h expected 12340100", part_data); end
    vec_count++; if (grant_id !== 2'd0) begin miss_count++; $display("[TB] FAIL single_grant_id: got %0d expected 0", grant_id); end
    vec_count++; if (req_ready !== 4'b0000) begin miss_count++; $display("[TB] FAIL single_ready_busy: got %b expected 0000", req_ready); end
    req_valid  = '0;
    part_ready = 1'b1;
    tick();
    part_ready = 1'b0;
    vec_count++; if (part_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL single_part_drop: got %b expected 0", part_valid); end
    vec_count++; if (wl_ready !== 1'b1) begin miss_count++; $display("[TB] FAIL single_wl_ready: got %b expected 1", wl_ready); end
    vec_count++; if (pp_ready !== 1'b1) begin miss_count++; $display("[TB] FAIL single_pp_ready: got %b expected 1", pp_ready); end
    wl_valid = 1'b1;
    tick();
    wl_valid = 1'b0;
    vec_count++; if (done !== 4'b0001) begin miss_count++; $display("[TB] FAIL single_done: got %b expected 0001", done); end
    tick();
    vec_count++; if (done !== 4'b0000) begin miss_count++; $display("[TB] FAIL single_done_clear: got %b expected 0000", done); end
    vec_count++; if (busy !== 1'b0) begin miss_count++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
    vec_count++; if (grant_id !== 2'd0) begin miss_count++; $display("[TB] FAIL single_grant_hold: got %0d expected 0", grant_id); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic [3:0] exp_oh;
    logic [31:0] exp_data;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = 32'hA000_0000 + i;
    for (int t = 0; t < 5; t++) begin
      exp_id   = 2'(t % 4);
      exp_oh   = 4'b0001 << exp_id;
      exp_data = 32'hA000_0000 + 32'(exp_id);
      req_valid = 4'b1111;
      #1;
      vec_count++; if (req_ready !== exp_oh) begin miss_count++; $display("[TB] FAIL rr_req_ready_%0d: got %b expected %b", t, req_ready, exp_oh); end
      tick();
      vec_count++; if (grant_id !== exp_id) begin miss_count++; $display("[TB] FAIL rr_grant_%0d: got %0d expected %0d", t, grant_id, exp_id); end
      vec_count++; if (part_data !== exp_data) begin miss_count++; $display("[TB] FAIL rr_data_%0d: got %h expected %h", t, part_data, exp_data); end
      part_ready = 1'b1;
      tick();
      part_ready = 1'b0;
      vec_count++; if (done !== 4'b0000) begin miss_count++; $display("[TB] FAIL rr_done_early_%0d: got %b expected 0000", t, done); end
      wl_valid = 1'b1;
      tick();
      wl_valid = 1'b0;
      vec_count++; if (done !== exp_oh) begin miss_count++; $display("[TB] FAIL rr_done_%0d: got %b expected %b", t, done, exp_oh); end
      tick();
      vec_count++; if (done !== 4'b0000) begin miss_count++; $display("[TB] FAIL rr_done_once_%0d: got %b expected 0000", t, done); end
    end
    req_valid = '0;
  endtask

  task automatic test_credits();
    int hs;
    do_reset();
    start_txn(4'b0001);
    drain(8, hs);
    vec_count++; if (hs !== 4) begin miss_count++; $display("[TB] FAIL credit_init_drain: got %0d expected 4", hs); end
    vec_count++; if (pp_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL credit_empty: got %b expected 0", pp_ready); end
    pulse_ret(1);
    drain(3, hs);
    vec_count++; if (hs !== 1) begin miss_count++; $display("[TB] FAIL credit_one_ret: got %0d expected 1", hs); end
    pulse_ret(1);
    pp_valid   = 1'b1;
    credit_ret = 1'b1;
    #1;
    vec_count++; if (pp_ready !== 1'b1) begin miss_count++; $display("[TB] FAIL credit_simul_ready: got %b expected 1", pp_ready); end
    tick();
    pp_valid   = 1'b0;
    credit_ret = 1'b0;
    drain(3, hs);
    vec_count++; if (hs !== 1) begin miss_count++; $display("[TB] FAIL credit_simul_hold: got %0d expected 1", hs); end
    pulse_ret(4);
    pulse_ret(9);
    drain(12, hs);
    vec_count++; if (hs !== 8) begin miss_count++; $display("[TB] FAIL credit_saturate: got %0d expected 8", hs); end
    finish_txn();
    pulse_ret(3);
    start_txn(4'b0010);
    pp_valid = 1'b1;
    wl_valid = 1'b1;
    #1;
    vec_count++; if ({pp_ready, wl_ready} !== 2'b11) begin miss_count++; $display("[TB] FAIL pp_wl_same_ready: got %b expected 11", {pp_ready, wl_ready}); end
    tick();
    pp_valid = 1'b0;
    vec_count++; if (done !== 4'b0010) begin miss_count++; $display("[TB] FAIL pp_wl_same_done: got %b expected 0010", done); end
    vec_count++; if (wl_ready !== 1'b0) begin miss_count++; $display("[TB] FAIL finish_wl_ready: got %b expected 0", wl_ready); end
    tick();
    wl_valid = 1'b0;
    vec_count++; if ({busy, done} !== 5'b0) begin miss_count++; $display("[TB] FAIL wl_after_ignored: got %b expected 00000", {busy, done}); end
    start_txn(4'b0100);
    drain(5, hs);
    vec_count++; if (hs !== 2) begin miss_count++; $display("[TB] FAIL credit_idle_ret: got %0d expected 2", hs); end
    finish_txn();
  endtask

  task automatic test_abort();
    int hs;
    do_reset();
    start_txn(4'b0100);
    finish_txn();
    start_txn(4'b0010);
    vec_count++; if (grant_id !== 2'd1) begin miss_count++; $display("[TB] FAIL abort_pre_grant: got %0d expected 1", grant_id); end
    drain(1, hs);
    wl_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    vec_count++; if ({busy, part_valid, pp_ready, wl_ready} !== 4'b0000) begin miss_count++; $display("[TB] FAIL abort_async: got %b expected 0000", {busy, part_valid, pp_ready, wl_ready}); end
    vec_count++; if (done !== 4'b0000) begin miss_count++; $display("[TB] FAIL abort_done_async: got %b expected 0000", done); end
    tick();
    wl_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    vec_count++; if ({busy, done} !== 5'b0) begin miss_count++; $display("[TB] FAIL abort_no_done: got %b expected 00000", {busy, done}); end
    vec_count++; if (grant_id !== 2'd0) begin miss_count++; $display("[TB] FAIL abort_grant_id: got %0d expected 0", grant_id); end
    req_valid = 4'b1111;
    #1;
    vec_count++; if (req_ready !== 4'b0001) begin miss_count++; $display("[TB] FAIL abort_pointer: got %b expected 0001", req_ready); end
    tick();
    req_valid  = '0;
    part_ready = 1'b1;
    tick();
    part_ready = 1'b0;
    drain(6, hs);
    vec_count++; if (hs !== CREDIT_INIT) begin miss_count++; $display("[TB] FAIL abort_credit: got %0d expected %0d", hs, CREDIT_INIT); end
    finish_txn();
  endtask

  task automatic test_timeout();
    logic exp_err;
`ifdef PARTITION_ARB_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    start_txn(4'b0001);
    repeat (15) tick();
    vec_count++; if (timeout_err !== 1'b0) begin miss_count++; $display("[TB] FAIL timeout_early: got %b expected 0", timeout_err); end
    tick();
    vec_count++; if (timeout_err !== exp_err) begin miss_count++; $display("[TB] FAIL timeout_rise: got %b expected %b", timeout_err, exp_err); end
    finish_txn();
    vec_count++; if (timeout_err !== exp_err) begin miss_count++; $display("[TB] FAIL timeout_sticky: got %b expected %b", timeout_err, exp_err); end
    vec_count++; if (busy !== 1'b0) begin miss_count++; $display("[TB] FAIL timeout_fsm: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credits();
    test_abort();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
